// File: rtl/weight_loader.sv
// Packs a stream of weight words into rows and writes them to weight_storage
// row-major over rows 0..size-1 of layers 0..N-1.
module weight_loader #(
    parameter int data_size  = 16,
    parameter int size       = 3,
    parameter int layer_size = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [31:0]               load_layers,
    input  logic                      abort,
    input  logic [data_size-1:0]      in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [31:0]               write_layer_index,
    output logic [31:0]               write_row_index,
    output logic [data_size*size-1:0] write_data,
    output logic                      is_write,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);
    localparam int CW = (size > 1) ? $clog2(size) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    state_t                           state_q, state_d;
    logic [CW-1:0]                    col_q, col_d;
    logic [31:0]                      row_q, row_d;
    logic [31:0]                      layer_q, layer_d;
    logic [31:0]                      n_q, n_d;
    logic [size-1:0][data_size-1:0]   pack_q, pack_d;
    logic [size-1:0][data_size-1:0]   wdata_q, wdata_d;
    logic                             error_q, error_d;
    logic [CW-1:0]                    slot;
    logic                             legal;

    assign legal = (load_layers != 32'd0) && (load_layers <= 32'(layer_size));
    // First word of a row lands in the most significant slice.
    assign slot  = CW'(size - 1) - col_q;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        layer_d = layer_q;
        n_d     = n_q;
        pack_d  = pack_q;
        wdata_d = wdata_q;
        error_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!abort && start) begin
                    if (legal) begin
                        n_d     = load_layers;
                        col_d   = '0;
                        row_d   = '0;
                        layer_d = '0;
                        state_d = COLLECT;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (in_valid) begin
                    pack_d[slot] = in_data;
                    if (col_q == CW'(size - 1)) begin
                        // Output register only changes here, so write_data holds between writes.
                        col_d   = '0;
                        wdata_d = pack_d;
                        state_d = WRITE;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (row_q == 32'(size - 1)) begin
                    row_d = '0;
                    if (layer_q == n_q - 32'd1) begin
                        layer_d = '0;
                        state_d = DONE;
                    end else begin
                        layer_d = layer_q + 32'd1;
                        state_d = COLLECT;
                    end
                end else begin
                    row_d   = row_q + 32'd1;
                    state_d = COLLECT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            layer_q <= '0;
            n_q     <= '0;
            pack_q  <= '0;
            wdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            layer_q <= layer_d;
            n_q     <= n_d;
            pack_q  <= pack_d;
            wdata_q <= wdata_d;
            error_q <= error_d;
        end
    end

    assign in_ready          = (state_q == COLLECT);
    assign is_write          = (state_q == WRITE);
    assign busy              = (state_q == COLLECT) || (state_q == WRITE);
    assign done              = (state_q == DONE);
    assign error             = error_q;
    assign write_row_index   = row_q;
    assign write_layer_index = layer_q;
    assign write_data        = wdata_q;

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: start/illegal-start table, row packing,
// stalls, abort, reset mid-load and start-while-busy.
module tb_weight_loader;
    localparam int DW = 16;
    localparam int SZ = 3;
    localparam int LS = 5;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [31:0]       load_layers;
    logic              abort;
    logic [DW-1:0]     in_data;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       write_layer_index;
    logic [31:0]       write_row_index;
    logic [DW*SZ-1:0]  write_data;
    logic              is_write;
    logic              busy;
    logic              done;
    logic              error;

    weight_loader #(.data_size(DW), .size(SZ), .layer_size(LS)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .load_layers       (load_layers),
        .abort             (abort),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .write_layer_index (write_layer_index),
        .write_row_index   (write_row_index),
        .write_data        (write_data),
        .is_write          (is_write),
        .busy              (busy),
        .done              (done),
        .error             (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]      layer;
        logic [31:0]      row;
        logic [DW*SZ-1:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] ll;
        logic        exp_error;
        logic        exp_busy;
    } start_vec_t;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  last_acc = -10;
    int  last_wr = -10;
    int  done_cnt = 0;
    int  err_cnt = 0;
    wr_t wq[$];
    logic [DW*SZ-1:0] mem [LS][SZ];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] word(input int k);
        return DW'(k * 256);
    endfunction

    function automatic logic [DW*SZ-1:0] row_model(input int f, input int i);
        return {word(f + 3*i), word(f + 3*i + 1), word(f + 3*i + 2)};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_valid && in_ready) last_acc <= cyc;
    end

    // Passive monitor: records writes, checks latency and done timing.
    always @(negedge clk) begin
        if (is_write) begin
            wq.push_back('{write_layer_index, write_row_index, write_data});
            check("write latency", 64'(cyc), 64'(last_acc + 1));
            check("write index range", 64'((write_layer_index < LS) && (write_row_index < SZ)), 64'd1);
            if (write_layer_index < LS && write_row_index < SZ)
                mem[write_layer_index][write_row_index] = write_data;
            last_wr = cyc;
        end
        if (done) begin
            done_cnt++;
            check("done after last write", 64'(cyc), 64'(last_wr + 1));
        end
        if (error) err_cnt++;
    end

    task automatic do_start(input logic [31:0] n);
        @(negedge clk);
        start = 1'b1;
        load_layers = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input int first, input int count, input bit stall);
        int sent = 0;
        int ph = 0;
        int cnt = 0;
        bit v;
        while (sent < count && cnt < count * 6 + 20) begin
            @(negedge clk);
            v = stall ? (ph % 3 == 0) : 1'b1;
            ph++;
            cnt++;
            if (in_ready && v) begin
                in_valid = 1'b1;
                in_data = word(first + sent);
                sent++;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("feed words accepted", 64'(sent), 64'(count));
    endtask

    task automatic verify_writes(input string tag, input int f, input int nexp);
        check({tag, " write count"}, 64'(wq.size()), 64'(nexp));
        for (int i = 0; i < wq.size() && i < nexp; i++) begin
            check({tag, " layer"}, 64'(wq[i].layer), 64'(i / SZ));
            check({tag, " row"},   64'(wq[i].row),   64'(i % SZ));
            check({tag, " data"},  64'(wq[i].data),  64'(row_model(f, i)));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " busy"},     64'(busy), 64'd0);
        check({tag, " in_ready"}, 64'(in_ready), 64'd0);
        check({tag, " is_write"}, 64'(is_write), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end

    initial begin
        start_vec_t ill[4];
        wr_t        full[15];
        int         d0;

        ill[0] = '{32'd0,         1'b1, 1'b0};
        ill[1] = '{32'd6,         1'b1, 1'b0};
        ill[2] = '{32'd100,       1'b1, 1'b0};
        ill[3] = '{32'hFFFF_FFFF, 1'b1, 1'b0};
        full[0]  = '{32'd0, 32'd0, {16'h0100, 16'h0200, 16'h0300}};
        full[1]  = '{32'd0, 32'd1, {16'h0400, 16'h0500, 16'h0600}};
        full[2]  = '{32'd0, 32'd2, {16'h0700, 16'h0800, 16'h0900}};
        full[3]  = '{32'd1, 32'd0, {16'h0A00, 16'h0B00, 16'h0C00}};
        full[4]  = '{32'd1, 32'd1, {16'h0D00, 16'h0E00, 16'h0F00}};
        full[5]  = '{32'd1, 32'd2, {16'h1000, 16'h1100, 16'h1200}};
        full[6]  = '{32'd2, 32'd0, {16'h1300, 16'h1400, 16'h1500}};
        full[7]  = '{32'd2, 32'd1, {16'h1600, 16'h1700, 16'h1800}};
        full[8]  = '{32'd2, 32'd2, {16'h1900, 16'h1A00, 16'h1B00}};
        full[9]  = '{32'd3, 32'd0, {16'h1C00, 16'h1D00, 16'h1E00}};
        full[10] = '{32'd3, 32'd1, {16'h1F00, 16'h2000, 16'h2100}};
        full[11] = '{32'd3, 32'd2, {16'h2200, 16'h2300, 16'h2400}};
        full[12] = '{32'd4, 32'd0, {16'h2500, 16'h2600, 16'h2700}};
        full[13] = '{32'd4, 32'd1, {16'h2800, 16'h2900, 16'h2A00}};
        full[14] = '{32'd4, 32'd2, {16'h2B00, 16'h2C00, 16'h2D00}};

        rst_n = 1'b0; start = 1'b0; load_layers = '0; abort = 1'b0;
        in_data = '0; in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset done", 64'(done), 64'd0);
        check("reset error", 64'(error), 64'd0);
        check("reset data", 64'(write_data), 64'd0);
        check("reset layer idx", 64'(write_layer_index), 64'd0);
        check("reset row idx", 64'(write_row_index), 64'd0);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // Illegal start values
        for (int i = 0; i < 4; i++) begin
            do_start(ill[i].ll);
            check("illegal error pulse", 64'(error), 64'(ill[i].exp_error));
            check("illegal busy", 64'(busy), 64'(ill[i].exp_busy));
            @(negedge clk);
            check("illegal error cleared", 64'(error), 64'd0);
        end
        check("illegal error count", 64'(err_cnt), 64'd4);
        check("illegal no writes", 64'(wq.size()), 64'd0);

        // T1 single layer
        wq.delete();
        d0 = done_cnt;
        do_start(32'd1);
        check("T1 busy", 64'(busy), 64'd1);
        feed(1, 9, 1'b0);
        repeat (3) @(negedge clk);
        verify_writes("T1", 1, 3);
        check("T1 row0 data", 64'(wq[0].data), 64'h0100_0200_0300);
        check("T1 done count", 64'(done_cnt - d0), 64'd1);
        check_idle_outputs("T1 end");

        // T2 full load against table
        wq.delete();
        d0 = done_cnt;
        do_start(32'd5);
        feed(1, 45, 1'b0);
        repeat (3) @(negedge clk);
        check("T2 write count", 64'(wq.size()), 64'd15);
        for (int i = 0; i < 15 && i < wq.size(); i++)
            check("T2 write record", 64'(wq[i] != full[i]), 64'd0);
        for (int i = 0; i < 15; i++)
            check("T2 storage readback", 64'(mem[full[i].layer][full[i].row]), 64'(full[i].data));
        check("T2 done count", 64'(done_cnt - d0), 64'd1);

        // T3 stalled input
        wq.delete();
        d0 = done_cnt;
        do_start(32'd1);
        feed(101, 9, 1'b1);
        repeat (3) @(negedge clk);
        verify_writes("T3", 101, 3);
        check("T3 done count", 64'(done_cnt - d0), 64'd1);

        // T5a abort in COLLECT after 2 words of row 1
        wq.delete();
        d0 = done_cnt;
        do_start(32'd1);
        feed(1, 5, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle_outputs("T5 abort");
        repeat (4) @(negedge clk);
        verify_writes("T5 abort", 1, 1);
        check("T5 abort no done", 64'(done_cnt - d0), 64'd0);

        // T5b abort during WRITE: that write completes, nothing after
        wq.delete();
        do_start(32'd2);
        feed(1, 3, 1'b0);
        check("T5 in WRITE", 64'(is_write), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle_outputs("T5 write abort");
        repeat (4) @(negedge clk);
        verify_writes("T5 write abort", 1, 1);
        check("T5 write abort no done", 64'(done_cnt - d0), 64'd0);

        // T5c reset mid-load
        wq.delete();
        do_start(32'd1);
        feed(1, 4, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("T5 reset");
        check("T5 reset data", 64'(write_data), 64'd0);
        check("T5 reset row idx", 64'(write_row_index), 64'd0);
        check("T5 reset layer idx", 64'(write_layer_index), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        verify_writes("T5 reset", 1, 1);
        check("T5 reset no done", 64'(done_cnt - d0), 64'd0);

        // Clean load after reset starts from row 0 / layer 0
        wq.delete();
        do_start(32'd1);
        feed(201, 9, 1'b0);
        repeat (3) @(negedge clk);
        verify_writes("post reset", 201, 3);

        // T6 start while busy is ignored
        wq.delete();
        d0 = done_cnt;
        do_start(32'd2);
        feed(1, 4, 1'b0);
        do_start(32'd1);
        check("T6 still busy", 64'(busy), 64'd1);
        check("T6 no error", 64'(error), 64'd0);
        feed(5, 14, 1'b0);
        repeat (3) @(negedge clk);
        verify_writes("T6", 1, 6);
        check("T6 done count", 64'(done_cnt - d0), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
